// File: rtl/ttl_seq_pkg.sv
// ttl_seq_pkg: shared types for the timed TTL sequencer.
//   - seq_state_t : head-event FSM states
//   - ttl_evt_t   : event word layout for the default build
//                   (NUM_CH=16, TS_WIDTH=64, PW_WIDTH=16), LSB-first
//                   {pulse_width, mode, value, mask, timestamp}
//   - EVT_*       : field offsets of that default layout
package ttl_seq_pkg;

  localparam int unsigned EVT_TS_W      = 64;
  localparam int unsigned EVT_CH        = 16;
  localparam int unsigned EVT_PW_W      = 16;
  localparam int unsigned EVT_MASK_LSB  = EVT_TS_W;
  localparam int unsigned EVT_VALUE_LSB = EVT_MASK_LSB + EVT_CH;
  localparam int unsigned EVT_MODE_BIT  = EVT_VALUE_LSB + EVT_CH;
  localparam int unsigned EVT_PW_LSB    = EVT_MODE_BIT + 1;
  localparam int unsigned EVT_BITS      = EVT_PW_LSB + EVT_PW_W;

  typedef struct packed {
    logic [EVT_PW_W-1:0] pulse_width;
    logic                mode;
    logic [EVT_CH-1:0]   value;
    logic [EVT_CH-1:0]   mask;
    logic [EVT_TS_W-1:0] ts;
  } ttl_evt_t;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIRE} seq_state_t;

endpackage

// File: rtl/ttl_evt_fifo.sv
// ttl_evt_fifo: single-clock first-word-fall-through FIFO for event words.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : empties the FIFO on the next edge, overrides push/pop
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read acknowledge; dout always shows the oldest entry
//   full/empty : occupancy flags derived from the registered count
module ttl_evt_fifo #(
  parameter int DEPTH     = 64,
  parameter int ADDR_LEN  = 6,
  parameter int DIN_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DIN_WIDTH-1:0] din,
  output logic [DIN_WIDTH-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ADDR_LEN:0] FULL_CNT = (ADDR_LEN+1)'(DEPTH);

  logic [DIN_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_LEN-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_LEN:0]    count;
  logic                 do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ttl_seq_out.sv
// ttl_seq_out: timed multi-channel TTL sequencer.
// Buffers timestamped events and applies each one on the clock edge where
// the global counter equals its timestamp, so the new level is visible while
// counter == ts+1. Supports masked level updates and auto-clearing pulses.
//   clk, reset        : clock, asynchronous active-high reset
//   auto_start        : arm; head loading and firing happen only while high
//   flush             : discard FIFO contents and the head event
//   write, fifo_din   : event push {pulse_width, mode, value, mask, ts}
//   counter           : global time counter
//   full, empty       : FIFO full; FIFO and head both empty
//   ttl_out           : registered channel levels
//   counter_matched   : one-cycle pulse, event applied
//   timestamp_error   : one-cycle pulse, late event dropped
//   overflow_error    : one-cycle pulse, write while full dropped
//   error_data        : last dropped event word
// Optional macro TTL_SEQ_OVERRIDE_EN adds override_en / override_value /
// overrided to force the pads while the sequencer keeps running.
module ttl_seq_out
  import ttl_seq_pkg::*;
#(
  parameter int NUM_CH    = 16,
  parameter int DEPTH     = 64,
  parameter int ADDR_LEN  = 6,
  parameter int TS_WIDTH  = 64,
  parameter int PW_WIDTH  = 16,
  parameter int DIN_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 auto_start,
  input  logic                 flush,
  input  logic                 write,
  input  logic [DIN_WIDTH-1:0] fifo_din,
  input  logic [TS_WIDTH-1:0]  counter,
  output logic                 full,
  output logic                 empty,
  output logic [NUM_CH-1:0]    ttl_out,
  output logic                 counter_matched,
  output logic                 timestamp_error,
  output logic                 overflow_error,
`ifdef TTL_SEQ_OVERRIDE_EN
  input  logic                 override_en,
  input  logic [NUM_CH-1:0]    override_value,
  output logic                 overrided,
`endif
  output logic [DIN_WIDTH-1:0] error_data
);

  localparam int MASK_LSB  = TS_WIDTH;
  localparam int VALUE_LSB = MASK_LSB + NUM_CH;
  localparam int MODE_BIT  = VALUE_LSB + NUM_CH;
  localparam int PW_LSB    = MODE_BIT + 1;
  localparam logic [PW_WIDTH-1:0] PW_ONE = PW_WIDTH'(1);

  if (PW_LSB + PW_WIDTH > DIN_WIDTH) begin : g_bad_din_width
    $error("ttl_seq_out: event fields do not fit in DIN_WIDTH");
  end
  if ((1 << ADDR_LEN) != DEPTH) begin : g_bad_depth
    $error("ttl_seq_out: DEPTH must equal 2**ADDR_LEN");
  end

  seq_state_t           state_q, state_d;
  logic [DIN_WIDTH-1:0] head_q;
  logic [DIN_WIDTH-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty, fifo_pop, load_head;

  logic [TS_WIDTH-1:0]  h_ts;
  logic [NUM_CH-1:0]    h_mask, h_val;
  logic                 h_mode;
  logic [PW_WIDTH-1:0]  h_pw;
  logic                 apply, late, ovf_hit, pulse_evt;

  logic [NUM_CH-1:0]    lvl_q, lvl_d;
  logic [NUM_CH-1:0]    idle_lvl_q, idle_lvl_d;
  logic [PW_WIDTH-1:0]  timer_q [NUM_CH];
  logic [PW_WIDTH-1:0]  timer_d [NUM_CH];

  logic                 cm_q, ts_err_q, ovf_q;
  logic [DIN_WIDTH-1:0] err_data_q;

  ttl_evt_fifo #(
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN),
    .DIN_WIDTH(DIN_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .push (write),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign h_ts   = head_q[TS_WIDTH-1:0];
  assign h_mask = head_q[MASK_LSB +: NUM_CH];
  assign h_val  = head_q[VALUE_LSB +: NUM_CH];
  assign h_mode = head_q[MODE_BIT];
  assign h_pw   = head_q[PW_LSB +: PW_WIDTH];

  // The event is applied on the edge that sees counter == ts (leaving WAIT),
  // which is what makes the level visible at ts+1. FIRE is the following
  // bookkeeping cycle and may already pull the next event, giving 2-cycle
  // minimum spacing.
  assign apply     = (state_q == WAIT) && auto_start && !flush && (h_ts == counter);
  assign late      = (state_q == WAIT) && auto_start && !flush && (h_ts < counter);
  assign ovf_hit   = write && fifo_full && !flush;
  assign pulse_evt = h_mode && (h_pw != '0);

  // Loading is gated by auto_start so an unarmed sequencer leaves all DEPTH
  // entries available to the writer.
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    load_head = 1'b0;
    case (state_q)
      IDLE: if (auto_start && !fifo_empty) state_d = LOAD;
      LOAD: begin
        fifo_pop  = 1'b1;
        load_head = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (apply)     state_d = FIRE;
        else if (late) state_d = IDLE;
      end
      FIRE: begin
        if (auto_start && !fifo_empty) begin
          fifo_pop  = 1'b1;
          load_head = 1'b1;
          state_d   = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      fifo_pop  = 1'b0;
      load_head = 1'b0;
    end
  end

  // Per-channel timers: a running timer reaching its last count restores the
  // stored idle level; a new event on the channel takes precedence.
  always_comb begin
    lvl_d      = lvl_q;
    idle_lvl_d = idle_lvl_q;
    for (int i = 0; i < NUM_CH; i++) begin
      timer_d[i] = timer_q[i];
      if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - PW_ONE;
        if (timer_q[i] == PW_ONE) lvl_d[i] = idle_lvl_q[i];
      end
      if (apply && h_mask[i]) begin
        lvl_d[i] = h_val[i];
        if (pulse_evt) begin
          timer_d[i]    = h_pw;
          idle_lvl_d[i] = ~h_val[i];
        end else begin
          timer_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lvl_q      <= '0;
      idle_lvl_q <= '0;
      timer_q    <= '{default: '0};
      cm_q       <= 1'b0;
      ts_err_q   <= 1'b0;
      ovf_q      <= 1'b0;
      err_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      idle_lvl_q <= idle_lvl_d;
      timer_q    <= timer_d;
      cm_q       <= apply;
      ts_err_q   <= late;
      ovf_q      <= ovf_hit;
      if (ovf_hit)   err_data_q <= fifo_din;
      else if (late) err_data_q <= head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (load_head) head_q <= fifo_dout;
  end

`ifdef TTL_SEQ_OVERRIDE_EN
  logic [NUM_CH-1:0] out_q;
  logic              ovr_q;

  // Registered from the sequencer's next state so normal timing is unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      out_q <= override_en ? override_value : lvl_d;
      ovr_q <= override_en;
    end
  end

  assign ttl_out   = out_q;
  assign overrided = ovr_q;
`else
  assign ttl_out = lvl_q;
`endif

  assign full            = fifo_full;
  assign empty           = fifo_empty && (state_q != WAIT);
  assign counter_matched = cm_q;
  assign timestamp_error = ts_err_q;
  assign overflow_error  = ovf_q;
  assign error_data      = err_data_q;

endmodule

// File: doc/ttl_seq_out.md
Name: ttl_seq_out

Overview:
Parametrised successor to the single-path timed TTL output. Buffers timestamped multi-channel events in an internal FIFO and applies each event when the global 64-bit counter equals its timestamp. Adds per-channel masked updates, an auto-clearing pulse mode with per-channel width timers, and late/overflow error reporting. Sits between the AXI-to-FIFO bridge (write/full/empty side) and the pad-driving serializer (output side).

Parameters:
NUM_CH, 16, number of TTL channels (1..32)
DEPTH, 64, event FIFO entries (power of two)
ADDR_LEN, 6, log2(DEPTH)
TS_WIDTH, 64, timestamp/counter width
PW_WIDTH, 16, pulse-width field width in clk cycles
DIN_WIDTH, 128, event word width; elaboration error if TS_WIDTH+2*NUM_CH+1+PW_WIDTH > DIN_WIDTH

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
auto_start  in  1  arm; events fire only while high
flush  in  1  discard FIFO and head event
write  in  1  push fifo_din
fifo_din  in  DIN_WIDTH  event word, LSB-first: {pulse_width, mode, value[NUM_CH], mask[NUM_CH], timestamp[TS_WIDTH]}
counter  in  TS_WIDTH  global time counter
full  out  1  FIFO full
empty  out  1  FIFO and head register both empty
ttl_out  out  NUM_CH  registered channel levels
counter_matched  out  1  one-cycle pulse when an event is applied
timestamp_error  out  1  one-cycle pulse, late event dropped
overflow_error  out  1  one-cycle pulse, write while full dropped
error_data  out  DIN_WIDTH  last dropped event word, held until next error

Behaviour:
- Reset (async assert, sync release): ttl_out=0, all timers=0, FIFO empty, head invalid, all pulse outputs 0, error_data=0, full=0, empty=1.
- FIFO: write && !full pushes; write && full drops word, overflow_error=1 next cycle, error_data=fifo_din. full asserts the cycle after the DEPTH-th push.
- Head FSM: IDLE (head invalid) -> LOAD when FIFO non-empty: pop into head register, 1 cycle -> WAIT.
- WAIT, auto_start=0: hold; no late check.
- WAIT, auto_start=1: ts==counter -> FIRE; ts<counter (unsigned) -> drop, timestamp_error=1, error_data=head, -> IDLE; ts>counter -> hold.
- FIRE: next edge ttl_out[i] = value[i] for mask[i]=1, unchanged otherwise; counter_matched=1 same edge; -> IDLE. Output visible when counter==ts+1.
- Min event spacing 2 cycles; event with ts earlier than the preceding event's ts+2 is flagged late.
- Pulse mode (mode=1, pulse_width=N>0): each masked channel loads timer=N; timer decrements every cycle; on reaching 0 the channel is driven to ~value[i]. Output holds value for exactly N cycles. mode=1 with N=0 behaves as level mode.
- Level event on a channel with active timer cancels the timer.
- Pulse mode event on a channel with active timer reloads the timer.
- Timer expiry and new event on the same channel in the same cycle: event wins.
- flush: next edge FIFO empty and head invalid; ttl_out and running timers unaffected. flush+write same cycle: flush wins, write discarded, no overflow_error.
- auto_start deassert mid-WAIT: head retained.

Optional Feature:
TTL_SEQ_OVERRIDE_EN. When defined: adds ports override_en (in, 1), override_value (in, NUM_CH), overrided (out, 1). While override_en=1: ttl_out=override_value (registered, 1-cycle latency) and overrided=1; the sequencer, timers and error logic continue internally. On release, ttl_out returns to the internal state next cycle. When undefined: ports absent, ttl_out is always the sequencer state.

Decomposition:
- Package ttl_seq_pkg: event struct typedef (ts, mask, value, mode, pulse_width), field offset localparams, FSM state enum {IDLE, LOAD, WAIT, FIRE}.
- Sub-module ttl_evt_fifo: synchronous single-clock FIFO (DEPTH x DIN_WIDTH) with push, pop, full, empty, flush.
- Timer array and FSM stay in ttl_seq_out.

Test Plan:
- Level: push {ts=100, mask=0x0003, value=0x0001}, auto_start=1 -> ttl_out=0x0001 when counter==101; counter_matched pulses once.
- Pulse: push {ts=200, mask=0x0010, value=0x0010, mode=1, pw=5} -> ttl_out[4]=1 for counter 201..205, 0 from 206.
- Late: counter=500, push ts=400 -> timestamp_error pulse, error_data=word, ttl_out unchanged, empty=1.
- Overflow: 64 writes with auto_start=0 -> full=1; 65th write -> overflow_error, error_data=65th word; then flush+write same cycle -> empty=1, no error.
- Retrigger: pulse pw=10 on ch0 at ts=300, level event value=1 on ch0 at ts=305 -> ch0 stays 1 after 310.
- Async reset mid-pulse at counter=303 -> ttl_out=0 immediately; FIFO empty; no error pulses after release.
